// File: rtl/io_responder_if.sv
// io_responder_if: CPU-side I/O bus between the memory/IO splitter (master)
// and the I/O responder (slave). Reads are combinational; writes commit on
// the CPU clock edge.
interface io_responder_if;
    logic        io_read;
    logic        io_write;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output io_read,
        output io_write,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  io_read,
        input  io_write,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/io_responder.sv
// io_responder: memory-mapped I/O device on the CPU's I/O path.
// Provides debounced board switches (SW), a 24-bit LED register (LED) and,
// when the macro IO_TIMER_EN is defined, a down-counting timer (TCNT/TCTL).
// Without IO_TIMER_EN no timer flops exist and TCNT/TCTL read 0.
module io_responder #(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic              clock,
    input  logic              reset,
    io_responder_if.slave     bus,
    input  logic [23:0]       switch_in,
    output logic [23:0]       led_out
);

    typedef enum logic [7:0] {
        REG_SW   = 8'd0,
        REG_LED  = 8'd1,
        REG_TCNT = 8'd2,
        REG_TCTL = 8'd3
    } reg_e;

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Byte lanes inside a word are not decoded.
    logic [7:0] word;
    logic       addr_unused;
    assign word        = bus.addr[9:2];
    assign addr_unused = ^bus.addr[1:0];

    // ---------------------------------------------------------------
    // Switch path: 2-flop synchroniser + whole-vector debounce
    // ---------------------------------------------------------------
    logic [23:0]      sync1, sync2, sync_prev, sw_deb;
    logic [CNT_W-1:0] deb_cnt, deb_cnt_next;
    logic             sw_changed;

    // Next debounce count: restart on any change, saturate once stable.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        sw_changed   = (sync2 != sync_prev);
        deb_cnt_next = deb_cnt;
        if (sw_changed)
            deb_cnt_next = '0;
        else if (deb_cnt != CNT_MAX)
            deb_cnt_next = deb_cnt + CNT_W'(1);
    end

    // Synchronise, track stability and accept the value once it has held.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            sync_prev <= '0;
            deb_cnt   <= '0;
            sw_deb    <= '0;
        end else begin
            // NOTE: non-blocking assignments so each flop samples pre-edge values.
            sync1     <= switch_in;
            sync2     <= sync1;
            sync_prev <= sync2;
            deb_cnt   <= deb_cnt_next;
            if (!sw_changed && deb_cnt_next == CNT_MAX)
                sw_deb <= sync2;
        end
    end

    // ---------------------------------------------------------------
    // LED register
    // ---------------------------------------------------------------
    logic led_wr;
    assign led_wr = bus.io_write && (word == REG_LED);

    // LED register updates on the edge of a write to its offset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            led_out <= '0;
        else if (led_wr)
            led_out <= bus.wdata[23:0];
    end

    // ---------------------------------------------------------------
    // Optional timer
    // ---------------------------------------------------------------
    logic [31:0] tcnt_rd;
    logic [31:0] tctl_rd;

`ifdef IO_TIMER_EN
    logic [31:0] t_count, t_reload;
    logic        t_en, t_auto, t_done;
    logic        tcnt_wr, tctl_wr, t_expire;

    assign tcnt_wr  = bus.io_write && (word == REG_TCNT);
    assign tctl_wr  = bus.io_write && (word == REG_TCTL);
    // The 1->0 step; a CPU load of TCNT in the same cycle pre-empts it.
    assign t_expire = t_en && (t_count == 32'd1) && !tcnt_wr;

    assign tcnt_rd = t_count;
    assign tctl_rd = {29'd0, t_done, t_auto, t_en};

    // Timer count/reload/control; CPU load beats decrement, done-set beats clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            t_count  <= '0;
            t_reload <= '0;
            t_en     <= 1'b0;
            t_auto   <= 1'b0;
            t_done   <= 1'b0;
        end else begin
            if (tcnt_wr) begin
                t_count  <= bus.wdata;
                t_reload <= bus.wdata;
            end else if (t_en && t_count != 32'd0) begin
                if (t_expire)
                    t_count <= t_auto ? t_reload : 32'd0;
                else
                    t_count <= t_count - 32'd1;
            end

            if (tctl_wr) begin
                t_en   <= bus.wdata[0];
                t_auto <= bus.wdata[1];
            end

            if (t_expire)
                t_done <= 1'b1;
            else if (tctl_wr && bus.wdata[2])
                t_done <= 1'b0;
        end
    end
`else
    logic wdata_unused;
    assign wdata_unused = ^bus.wdata[31:24];
    assign tcnt_rd      = '0;
    assign tctl_rd      = '0;
`endif

    // ---------------------------------------------------------------
    // Combinational read mux; zero whenever no read is in progress.
    // ---------------------------------------------------------------
    always_comb begin
        bus.rdata = '0;
        if (bus.io_read) begin
            case (word)
                REG_SW:   bus.rdata = {8'd0, sw_deb};
                REG_LED:  bus.rdata = {8'd0, led_out};
                REG_TCNT: bus.rdata = tcnt_rd;
                REG_TCTL: bus.rdata = tctl_rd;
                default:  bus.rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder: directed self-checking bench for io_responder with
// DEBOUNCE_CYCLES=4. Timer checks follow the IO_TIMER_EN build option.
module tb_io_responder;

    localparam int DEB = 4;

    localparam logic [9:0] A_SW   = 10'h000;
    localparam logic [9:0] A_LED  = 10'h004;
    localparam logic [9:0] A_TCNT = 10'h008;
    localparam logic [9:0] A_TCTL = 10'h00C;
    localparam logic [9:0] A_NONE = 10'h010;

    logic        clock = 1'b0;
    logic        reset;
    logic [23:0] switch_in;
    logic [23:0] led_out;

    int total = 0;
    int bad   = 0;

    io_responder_if bus ();

    io_responder #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .switch_in (switch_in),
        .led_out   (led_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs and reads happen at edge+1.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rd_check(input string tag, input logic [9:0] a, input logic [31:0] exp);
        bus.addr    = a;
        bus.io_read = 1'b1;
        #1;
        check(tag, bus.rdata, exp);
        bus.io_read = 1'b0;
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        bus.addr     = a;
        bus.wdata    = d;
        bus.io_write = 1'b1;
        tick();
        bus.io_write = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        switch_in    = 24'hA5A5A5;
        bus.io_read  = 1'b0;
        bus.io_write = 1'b0;
        bus.addr     = '0;
        bus.wdata    = '0;

        // Reset: switches and LED held at zero while reset is high.
        repeat (3) tick();
        rd_check("sw_in_reset", A_SW, 32'h0);
        check("led_in_reset", {8'd0, led_out}, 32'h0);

        // Release: SW shows the switches exactly 6 edges later.
        reset = 1'b0;
        repeat (5) tick();
        rd_check("sw_rel_5", A_SW, 32'h0);
        check("led_after_rel", {8'd0, led_out}, 32'h0);
        tick();
        rd_check("sw_rel_6", A_SW, 32'h00A5A5A5);

        // LED write, readback, unmapped read, idle read.
        wr(A_LED, 32'h12345678);
        check("led_write", {8'd0, led_out}, 32'h00345678);
        rd_check("led_read", A_LED, 32'h00345678);
        rd_check("unmapped_read", A_NONE, 32'h0);
        rd_check("led_read_lowbits", 10'h007, 32'h00345678);
        bus.addr = A_LED;
        #1;
        check("rdata_idle", bus.rdata, 32'h0);

        // Read and write together: read sees the pre-write value.
        bus.addr     = A_LED;
        bus.wdata    = 32'h00ABCDEF;
        bus.io_read  = 1'b1;
        bus.io_write = 1'b1;
        #1;
        check("rw_same_cycle_read", bus.rdata, 32'h00345678);
        tick();
        bus.io_read  = 1'b0;
        bus.io_write = 1'b0;
        check("rw_same_cycle_led", {8'd0, led_out}, 32'h00ABCDEF);

        // Unmapped write ignored.
        wr(A_NONE, 32'hFFFFFFFF);
        rd_check("unmapped_wr_led", A_LED, 32'h00ABCDEF);
        rd_check("unmapped_wr_rd", A_NONE, 32'h0);

        // 3-cycle glitch never reaches SW.
        switch_in = 24'hFFFFFF;
        repeat (3) tick();
        switch_in = 24'hA5A5A5;
        for (int i = 0; i < 10; i++) begin
            tick();
            rd_check("glitch_filtered", A_SW, 32'h00A5A5A5);
        end

        // Held change appears exactly 6 edges later.
        switch_in = 24'h5A5A5A;
        repeat (5) tick();
        rd_check("held_5", A_SW, 32'h00A5A5A5);
        tick();
        rd_check("held_6", A_SW, 32'h005A5A5A);

`ifdef IO_TIMER_EN
        // One-shot: TCNT=3, en=1 -> 2,1,0 then sticky done.
        wr(A_TCNT, 32'd3);
        rd_check("tcnt_load", A_TCNT, 32'd3);
        wr(A_TCTL, 32'h1);
        rd_check("tcnt_en_edge", A_TCNT, 32'd3);
        tick();
        rd_check("tcnt_2", A_TCNT, 32'd2);
        tick();
        rd_check("tcnt_1", A_TCNT, 32'd1);
        rd_check("tctl_pre_done", A_TCTL, 32'h1);
        tick();
        rd_check("tcnt_0", A_TCNT, 32'd0);
        rd_check("tctl_done", A_TCTL, 32'h5);
        tick();
        rd_check("tcnt_idle", A_TCNT, 32'd0);
        rd_check("tctl_done_sticky", A_TCTL, 32'h5);
        wr(A_TCTL, 32'h5);
        rd_check("tctl_w1c", A_TCTL, 32'h1);

        // Auto-reload period 2.
        wr(A_TCTL, 32'h3);
        wr(A_TCNT, 32'd2);
        rd_check("auto_load", A_TCNT, 32'd2);
        tick();
        rd_check("auto_1", A_TCNT, 32'd1);
        rd_check("auto_tctl_1", A_TCTL, 32'h3);
        tick();
        rd_check("auto_reload", A_TCNT, 32'd2);
        rd_check("auto_done", A_TCTL, 32'h7);
        tick();
        rd_check("auto_1b", A_TCNT, 32'd1);
        // Clear on the 1->0 cycle: set wins.
        wr(A_TCTL, 32'h7);
        rd_check("set_beats_clear", A_TCTL, 32'h7);
        rd_check("auto_reload_b", A_TCNT, 32'd2);
        wr(A_TCTL, 32'h7);
        rd_check("clear_ok", A_TCTL, 32'h3);
        rd_check("auto_1c", A_TCNT, 32'd1);
        tick();
        rd_check("auto_reload_c", A_TCNT, 32'd2);
        // TCNT write in a decrement cycle wins.
        wr(A_TCNT, 32'd7);
        rd_check("write_beats_dec", A_TCNT, 32'd7);
        tick();
        rd_check("dec_after_write", A_TCNT, 32'd6);

        // Reset mid-count clears everything; no count until en rewritten.
        reset = 1'b1;
        #1;
        rd_check("rst_tcnt", A_TCNT, 32'd0);
        rd_check("rst_tctl", A_TCTL, 32'd0);
        check("rst_led", {8'd0, led_out}, 32'h0);
        rd_check("rst_sw", A_SW, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        wr(A_TCNT, 32'd5);
        tick();
        tick();
        rd_check("no_resume", A_TCNT, 32'd5);
`else
        // No timer: TCNT/TCTL ignore writes and read 0.
        wr(A_TCNT, 32'hFFFFFFFF);
        wr(A_TCTL, 32'h7);
        tick();
        rd_check("notimer_tcnt", A_TCNT, 32'd0);
        rd_check("notimer_tctl", A_TCTL, 32'd0);
        rd_check("notimer_led", A_LED, 32'h00ABCDEF);

        // Async reset clears LED and switches immediately.
        reset = 1'b1;
        #1;
        check("rst_led", {8'd0, led_out}, 32'h0);
        rd_check("rst_sw", A_SW, 32'h0);
        tick();
        reset = 1'b0;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_responder.md
# io_responder

Memory-mapped I/O responder on the CPU's I/O path: the device end of the interface the CPU drives through its memory/IO splitter when the upper address bits select I/O. It synchronises and debounces the 24 board switches, holds the 24-bit LED register, and optionally provides a down-counting timer. Reads return data combinationally within the single-cycle CPU's instruction. Writes commit on the clock edge.

## Interface
- `DEBOUNCE_CYCLES`, default 20000: consecutive stable cycles required before the switch value is accepted.
- `clock`  in  1  CPU clock (same clock as the register file and data memory).
- `reset`  in  1  Asynchronous, active-high reset.
- `io_read`  in  1  I/O read strobe from the memory/IO splitter.
- `io_write`  in  1  I/O write strobe.
- `addr`  in  10  Byte offset inside the I/O window. Bits [1:0] are ignored.
- `wdata`  in  32  Write data.
- `rdata`  out  32  Read data. It is 0 when `io_read` is low.
- `switch_in`  in  24  Raw, asynchronous board switches.
- `led_out`  out  24  LED register.

## Operation
- Register map (word offsets):
  - 0x000 SW: read-only. Returns {8'b0, debounced switches}.
  - 0x004 LED: read/write. A write stores `wdata[23:0]`; a read returns {8'b0, led}.
  - 0x008 TCNT: read/write. A write loads both count and reload with `wdata`. A read returns count.
  - 0x00C TCTL: bit0 `en` (RW), bit1 `auto` (RW), bit2 `done` (sticky, write-1-to-clear). Other bits read 0.
  - Unmapped offsets read 0. Writes to unmapped offsets are ignored.
- Switch path:
  - 2-flop synchroniser, then a debounce counter over the whole 24-bit vector.
  - The counter resets whenever the synchronised value differs from the previous cycle's.
  - When the counter reaches `DEBOUNCE_CYCLES-1` with the value unchanged, the debounced register takes the synchronised value.
  - The counter saturates while the value stays stable.
- Timer (see Configuration):
  - While `en`=1 and count≠0, count decrements by 1 every cycle.
  - On the 1→0 step, `done` is set. If `auto`=1, count loads reload instead of 0.
  - If reload=0, count stays 0 and the timer idles.
  - With count=0 and `auto`=0, the timer idles and `done` does not re-set.
- Simultaneous events:
  - A CPU write to TCNT in the same cycle as a decrement: the write wins.
  - A `done` set and a write-1-to-clear in the same cycle: the set wins.
  - `io_read` and `io_write` both high: the read returns the pre-write value, and the write commits at the edge.

## Timing
- Reset (async assert, values held until deassert):
  - `led_out`=0, debounced switches=0, synchroniser=0, debounce counter=0.
  - count=0, reload=0, `en`=0, `auto`=0, `done`=0, `rdata`=0.
- Read latency is 0 cycles: `rdata` is a combinational function of `addr`, `io_read` and the current register state.
- Write latency is 1 edge: `led_out` and the timer registers show the new value after the rising edge on which `io_write` is high.
- Switch latency: a stable input change appears at SW after 2 synchroniser cycles plus `DEBOUNCE_CYCLES` cycles. A glitch shorter than `DEBOUNCE_CYCLES` never appears.
- Timer: after a write of N to TCNT and `en`=1, `done` rises N edges after the first enabled edge.
- Reset asserted mid-count clears everything immediately. Counting does not resume until `en` is rewritten.

## Configuration
- `IO_TIMER_EN` defined: the timer registers and logic are built as described.
- `IO_TIMER_EN` undefined: no timer flops exist. TCNT and TCTL read 0 and ignore writes. All other behaviour is identical.

## Test plan
- Reset with `switch_in`=0xA5A5A5, `DEBOUNCE_CYCLES`=4 → SW reads 0 during reset; 6 cycles after release SW reads 0x00A5A5A5; `led_out`=0 throughout.
- Write 0x12345678 to 0x004 → `led_out`=0x345678 after the edge; read 0x004 returns 0x00345678; read 0x010 returns 0.
- `DEBOUNCE_CYCLES`=4: a 3-cycle pulse of 0xFFFFFF on `switch_in` → SW unchanged. A held change → SW updates exactly 6 cycles after it.
- Write TCNT=3, then TCTL=1 → count reads 2,1,0 on successive cycles; `done`=1 after the third edge and stays 1; writing TCTL=0x5 clears `done` and keeps `en`=1.
- TCNT=2, TCTL=0x3 → `done` set and count reloads to 2 each period. A write-1-to-clear landing on the 1→0 cycle leaves `done`=1. A TCNT write of 7 during a decrement cycle → count reads 7.
- Build without `IO_TIMER_EN` → writes to 0x008/0x00C have no effect; both read 0.
